// File: rtl/rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// rom_port_arbiter
//   Shares one single-port synchronous ROM RAM between the HPS download stream
//   and two CPU read ports (main CPU and sound CPU).
//   - Download writes go through a one-entry hold register and preempt reads.
//   - CPU reads are round-robin with a req/ack handshake.
//   - RAM address/write-enable/write-data are registered.
//   - RAM read data is valid one cycle after the address.
// Ports
//   MCLK, RESET             : core clock, asynchronous active-high reset
//   DL_ACTIVE/DL_WR/AD/DT   : download stream (strobe has no backpressure)
//   DL_DONE                 : one-cycle pulse once the download has fully landed
//   DL_OVF                  : sticky flag, a download byte was dropped
//   Cx_REQ/Cx_AD            : CPU read request; held until Cx_ACK
//   Cx_ACK/Cx_DT            : one-cycle ack; data held until the next ack
//   RAM_AD/RAM_WE/RAM_DI    : registered RAM controls
//   RAM_DO                  : RAM read data
// ---------------------------------------------------------------------------
module rom_port_arbiter #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          MCLK,
  input  logic          RESET,
  input  logic          DL_ACTIVE,
  input  logic          DL_WR,
  input  logic [AW-1:0] DL_AD,
  input  logic [DW-1:0] DL_DT,
  output logic          DL_DONE,
  output logic          DL_OVF,
  input  logic          C0_REQ,
  input  logic [AW-1:0] C0_AD,
  output logic          C0_ACK,
  output logic [DW-1:0] C0_DT,
  input  logic          C1_REQ,
  input  logic [AW-1:0] C1_AD,
  output logic          C1_ACK,
  output logic [DW-1:0] C1_DT,
  output logic [AW-1:0] RAM_AD,
  output logic          RAM_WE,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DATA  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          hold_v_q, hold_v_d;
  logic [AW-1:0] hold_ad_q, hold_ad_d;
  logic [DW-1:0] hold_dt_q, hold_dt_d;
  logic          ovf_q, ovf_d;
  logic          gnt_q, gnt_d;          // port owning the read in flight
  logic          rr_last_q, rr_last_d;  // port acked most recently
  logic          dl_pend_q, dl_pend_d;
  logic          dl_act_prev_q, dl_act_prev_d;
  logic          done_q, done_d;
  logic [AW-1:0] ram_ad_q, ram_ad_d;
  logic          ram_we_q, ram_we_d;
  logic [DW-1:0] ram_di_q, ram_di_d;
  logic          c0_ack_q, c0_ack_d;
  logic [DW-1:0] c0_dt_q, c0_dt_d;
  logic          c1_ack_q, c1_ack_d;
  logic [DW-1:0] c1_dt_q, c1_dt_d;

  logic elig0, elig1, pick, idle, drain, bypass;

  // Next-state logic: hold register, FSM, arbitration and download-done tracking
  always_comb begin
    state_d       = state_q;
    hold_v_d      = hold_v_q;
    hold_ad_d     = hold_ad_q;
    hold_dt_d     = hold_dt_q;
    ovf_d         = ovf_q;
    gnt_d         = gnt_q;
    rr_last_d     = rr_last_q;
    dl_pend_d     = dl_pend_q;
    dl_act_prev_d = DL_ACTIVE;
    done_d        = 1'b0;
    ram_ad_d      = ram_ad_q;
    ram_we_d      = ram_we_q;
    ram_di_d      = ram_di_q;
    c0_ack_d      = 1'b0;
    c0_dt_d       = c0_dt_q;
    c1_ack_d      = 1'b0;
    c1_dt_d       = c1_dt_q;

    // A port whose ack is high this cycle is dropping REQ; skip it.
    elig0  = C0_REQ & ~c0_ack_q;
    elig1  = C1_REQ & ~c1_ack_q;
    // Both eligible: the port not served last wins.
    pick   = (elig0 & elig1) ? ~rr_last_q : elig1;
    idle   = (state_q == ST_IDLE);
    drain  = idle & hold_v_q;
    // An idle arbiter with an empty hold writes the incoming byte straight
    // through, so a write strobe always beats a same-cycle read request.
    bypass = idle & ~hold_v_q & DL_WR;

    // Hold register: accept on empty or draining, otherwise drop and flag.
    if (drain) begin
      hold_v_d = DL_WR;
      if (DL_WR) begin
        hold_ad_d = DL_AD;
        hold_dt_d = DL_DT;
      end else begin
        hold_ad_d = hold_ad_q;
      end
    end else if (bypass) begin
      hold_v_d = 1'b0;
    end else if (DL_WR) begin
      if (hold_v_q) begin
        ovf_d = 1'b1;
      end else begin
        hold_v_d  = 1'b1;
        hold_ad_d = DL_AD;
        hold_dt_d = DL_DT;
      end
    end else begin
      hold_v_d = hold_v_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_v_q) begin
          ram_ad_d = hold_ad_q;
          ram_di_d = hold_dt_q;
          ram_we_d = 1'b1;
          state_d  = ST_WRITE;
        end else if (DL_WR) begin
          ram_ad_d = DL_AD;
          ram_di_d = DL_DT;
          ram_we_d = 1'b1;
          state_d  = ST_WRITE;
        end else if (!DL_ACTIVE && (elig0 || elig1)) begin
          gnt_d    = pick;
          ram_ad_d = pick ? C1_AD : C0_AD;
          ram_we_d = 1'b0;
          state_d  = ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: begin
        ram_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
      ST_READ: begin
        state_d = ST_DATA;
      end
      ST_DATA: begin
        if (gnt_q) begin
          c1_dt_d  = RAM_DO;
          c1_ack_d = 1'b1;
        end else begin
          c0_dt_d  = RAM_DO;
          c0_ack_d = 1'b1;
        end
        rr_last_d = gnt_q;
        state_d   = ST_IDLE;
      end
      default: begin
        ram_we_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Download completion: arm on DL_ACTIVE falling, fire once everything landed.
    done_d = dl_pend_q & ~hold_v_q & idle;
    if (dl_act_prev_q && !DL_ACTIVE) begin
      dl_pend_d = 1'b1;
    end else if (done_d) begin
      dl_pend_d = 1'b0;
    end else begin
      dl_pend_d = dl_pend_q;
    end
  end

  // State and output registers
  always_ff @(posedge MCLK or posedge RESET) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      hold_v_q      <= 1'b0;
      hold_ad_q     <= {AW{1'b0}};
      hold_dt_q     <= {DW{1'b0}};
      ovf_q         <= 1'b0;
      gnt_q         <= 1'b0;
      rr_last_q     <= 1'b1;
      dl_pend_q     <= 1'b0;
      dl_act_prev_q <= 1'b0;
      done_q        <= 1'b0;
      ram_ad_q      <= {AW{1'b0}};
      ram_we_q      <= 1'b0;
      ram_di_q      <= {DW{1'b0}};
      c0_ack_q      <= 1'b0;
      c0_dt_q       <= {DW{1'b0}};
      c1_ack_q      <= 1'b0;
      c1_dt_q       <= {DW{1'b0}};
    end else begin
      state_q       <= state_d;
      hold_v_q      <= hold_v_d;
      hold_ad_q     <= hold_ad_d;
      hold_dt_q     <= hold_dt_d;
      ovf_q         <= ovf_d;
      gnt_q         <= gnt_d;
      rr_last_q     <= rr_last_d;
      dl_pend_q     <= dl_pend_d;
      dl_act_prev_q <= dl_act_prev_d;
      done_q        <= done_d;
      ram_ad_q      <= ram_ad_d;
      ram_we_q      <= ram_we_d;
      ram_di_q      <= ram_di_d;
      c0_ack_q      <= c0_ack_d;
      c0_dt_q       <= c0_dt_d;
      c1_ack_q      <= c1_ack_d;
      c1_dt_q       <= c1_dt_d;
    end
  end

  assign DL_DONE = done_q;
  assign DL_OVF  = ovf_q;
  assign C0_ACK  = c0_ack_q;
  assign C0_DT   = c0_dt_q;
  assign C1_ACK  = c1_ack_q;
  assign C1_DT   = c1_dt_q;
  assign RAM_AD  = ram_ad_q;
  assign RAM_WE  = ram_we_q;
  assign RAM_DI  = ram_di_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_port_arbiter
//   Directed scenarios plus a randomized phase for rom_port_arbiter. A
//   behavioural RAM sits on the RAM port; expected read data comes from a
//   reference memory image, and expected RAM writes from an in-order queue of
//   accepted download bytes.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rom_port_arbiter;

  logic        MCLK = 1'b0;
  logic        RESET = 1'b1;
  logic        DL_ACTIVE = 1'b0, DL_WR = 1'b0;
  logic [15:0] DL_AD = 16'h0000;
  logic [7:0]  DL_DT = 8'h00;
  logic        DL_DONE, DL_OVF;
  logic        C0_REQ = 1'b0, C1_REQ = 1'b0;
  logic [15:0] C0_AD = 16'h0000, C1_AD = 16'h0000;
  logic        C0_ACK, C1_ACK;
  logic [7:0]  C0_DT, C1_DT;
  logic [15:0] RAM_AD;
  logic        RAM_WE;
  logic [7:0]  RAM_DI;
  logic [7:0]  RAM_DO;

  always #5 MCLK = ~MCLK;

  rom_port_arbiter #(.AW(16), .DW(8)) dut (
    .MCLK(MCLK), .RESET(RESET),
    .DL_ACTIVE(DL_ACTIVE), .DL_WR(DL_WR), .DL_AD(DL_AD), .DL_DT(DL_DT),
    .DL_DONE(DL_DONE), .DL_OVF(DL_OVF),
    .C0_REQ(C0_REQ), .C0_AD(C0_AD), .C0_ACK(C0_ACK), .C0_DT(C0_DT),
    .C1_REQ(C1_REQ), .C1_AD(C1_AD), .C1_ACK(C1_ACK), .C1_DT(C1_DT),
    .RAM_AD(RAM_AD), .RAM_WE(RAM_WE), .RAM_DI(RAM_DI), .RAM_DO(RAM_DO)
  );

  // ROM preload pattern; 0x1234 holds 8'hA5
  function automatic logic [7:0] init_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h83;
  endfunction

  // Behavioural single-port synchronous RAM
  logic [7:0] mem [0:65535];
  bit         wr_valid [0:65535];
  always @(posedge MCLK) begin
    if (RAM_WE) begin
      mem[RAM_AD]      <= RAM_DI;
      wr_valid[RAM_AD] <= 1'b1;
    end
    RAM_DO <= wr_valid[RAM_AD] ? mem[RAM_AD] : init_byte(RAM_AD);
  end

  function automatic logic [7:0] ram_byte(input logic [15:0] a);
    return wr_valid[a] ? mem[a] : init_byte(a);
  endfunction

  // Reference memory image: what the ROM should hold after accepted writes
  logic [7:0] ref_mem [0:65535];
  bit         ref_valid [0:65535];
  function automatic logic [7:0] ref_byte(input logic [15:0] a);
    return ref_valid[a] ? ref_mem[a] : init_byte(a);
  endfunction

  typedef struct packed { logic [15:0] ad; logic [7:0] dt; } wr_t;
  wr_t wr_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge MCLK);
    #1;
  endtask

  // Pulse a download byte that the arbiter is expected to accept
  task automatic dl_write(input logic [15:0] a, input logic [7:0] d);
    DL_WR = 1'b1;
    DL_AD = a;
    DL_DT = d;
    wr_q.push_back({a, d});
    ref_mem[a]   = d;
    ref_valid[a] = 1'b1;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    DL_ACTIVE = 1'b0; DL_WR = 1'b0; C0_REQ = 1'b0; C1_REQ = 1'b0;
    wr_q.delete();
    step();
    step();
    RESET = 1'b0;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_ram"}, {7'd0, RAM_AD, RAM_WE, RAM_DI}, 32'd0);
    check_eq({tag, "_cpu"}, {14'd0, C0_ACK, C0_DT, C1_ACK, C1_DT}, 32'd0);
    check_eq({tag, "_dl"}, {30'd0, DL_DONE, DL_OVF}, 32'd0);
  endtask

  // Monitor: read data, ack pulse width, and write ordering/content
  int ack_cnt0 = 0, ack_cnt1 = 0, done_cnt = 0;
  logic p0 = 1'b0, p1 = 1'b0, pwe = 1'b0;
  always @(negedge MCLK) begin
    if (!RESET) begin
      if (C0_ACK) begin
        ack_cnt0 <= ack_cnt0 + 1;
        check_eq("c0_data", C0_DT, ref_byte(C0_AD));
        check_eq("c0_ack_pulse", p0, 1'b0);
      end
      if (C1_ACK) begin
        ack_cnt1 <= ack_cnt1 + 1;
        check_eq("c1_data", C1_DT, ref_byte(C1_AD));
        check_eq("c1_ack_pulse", p1, 1'b0);
      end
      if (RAM_WE) begin
        check_eq("write_expected", wr_q.size() > 0, 1'b1);
        check_eq("we_pulse", pwe, 1'b0);
        if (wr_q.size() > 0) begin
          check_eq("write_addr", RAM_AD, wr_q[0].ad);
          check_eq("write_data", RAM_DI, wr_q[0].dt);
          wr_q.delete(0);
        end
      end
      if (DL_DONE) done_cnt <= done_cnt + 1;
    end
    p0  <= C0_ACK;
    p1  <= C1_ACK;
    pwe <= RAM_WE;
  end

  initial begin
    int order[$];
    int when[$];
    int base, d0, nbad, wait0, wait1, since_wr;

    // Reset state
    step();
    check_all_zero("reset");
    RESET = 1'b0;
    step();

    // 1: single read, grant after edge 1, ack after edge 3
    C0_AD = 16'h1234; C0_REQ = 1'b1;
    step();
    check_eq("t1_ram_ad", RAM_AD, 16'h1234);
    check_eq("t1_we", RAM_WE, 1'b0);
    check_eq("t1_ack_e1", C0_ACK, 1'b0);
    step();
    check_eq("t1_ack_e2", C0_ACK, 1'b0);
    step();
    check_eq("t1_ack_e3", C0_ACK, 1'b1);
    check_eq("t1_dt", C0_DT, 8'hA5);
    C0_REQ = 1'b0;
    step();
    check_eq("t1_ack_low", C0_ACK, 1'b0);
    check_eq("t1_dt_hold", C0_DT, 8'hA5);
    check_eq("t1_we_end", RAM_WE, 1'b0);

    // 2: contention from reset, both requests held
    do_reset();
    C0_AD = 16'h9000; C1_AD = 16'hA000;
    C0_REQ = 1'b1; C1_REQ = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      step();
      if (C0_ACK) begin order.push_back(0); when.push_back(c); end
      if (C1_ACK) begin order.push_back(1); when.push_back(c); end
    end
    C0_REQ = 1'b0; C1_REQ = 1'b0;
    check_eq("t2_nacks", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++) begin
      check_eq("t2_order", order[i], i % 2);
      check_eq("t2_cycle", when[i], 3 * (i + 1));
    end
    repeat (5) step();

    // 3: write preempts a same-cycle read request
    dl_write(16'h0010, 8'h3C);
    C1_AD = 16'hB000; C1_REQ = 1'b1;
    step();
    DL_WR = 1'b0;
    check_eq("t3_we", RAM_WE, 1'b1);
    check_eq("t3_ad", RAM_AD, 16'h0010);
    check_eq("t3_di", RAM_DI, 8'h3C);
    step();
    check_eq("t3_we_off", RAM_WE, 1'b0);
    step();
    check_eq("t3_rd_ad", RAM_AD, 16'hB000);
    check_eq("t3_ack_e3", C1_ACK, 1'b0);
    step();
    check_eq("t3_ack_e4", C1_ACK, 1'b0);
    step();
    check_eq("t3_ack_e5", C1_ACK, 1'b1);
    C1_REQ = 1'b0;
    repeat (3) step();

    // 4: overflow, two strobes back to back while a read is in flight
    C0_AD = 16'hC000; C0_REQ = 1'b1;
    step();
    dl_write(16'h0020, 8'h11);
    step();
    DL_AD = 16'h0021; DL_DT = 8'h22;   // second strobe, expected to be dropped
    step();
    DL_WR = 1'b0;
    check_eq("t4_ovf", DL_OVF, 1'b1);
    check_eq("t4_ack", C0_ACK, 1'b1);
    C0_REQ = 1'b0;
    step();
    check_eq("t4_we", RAM_WE, 1'b1);
    check_eq("t4_ad", RAM_AD, 16'h0020);
    check_eq("t4_di", RAM_DI, 8'h11);
    repeat (10) step();
    check_eq("t4_mem_first", ram_byte(16'h0020), 8'h11);
    check_eq("t4_mem_dropped", ram_byte(16'h0021), init_byte(16'h0021));
    check_eq("t4_ovf_sticky", DL_OVF, 1'b1);

    // 5: full download with CPU requests held throughout
    do_reset();
    check_eq("t5_ovf_cleared", DL_OVF, 1'b0);
    DL_ACTIVE = 1'b1;
    C0_AD = 16'hD000; C1_AD = 16'hE000;
    C0_REQ = 1'b1; C1_REQ = 1'b1;
    base = ack_cnt0 + ack_cnt1;
    d0 = done_cnt;
    for (int i = 0; i < 256; i++) begin
      dl_write(16'(i), 8'($urandom));
      step();
      DL_WR = 1'b0;
      repeat (5) step();
    end
    check_eq("t5_no_ack_active", ack_cnt0 + ack_cnt1 - base, 0);
    check_eq("t5_no_done_active", done_cnt - d0, 0);
    DL_ACTIVE = 1'b0;
    repeat (20) step();
    check_eq("t5_done_once", done_cnt - d0, 1);
    check_eq("t5_reads_resume", (ack_cnt0 + ack_cnt1 - base) > 0, 1'b1);
    check_eq("t5_ovf", DL_OVF, 1'b0);
    C0_REQ = 1'b0; C1_REQ = 1'b0;
    repeat (5) step();
    nbad = 0;
    for (int i = 0; i < 256; i++) begin
      if (ram_byte(16'(i)) !== ref_byte(16'(i))) nbad++;
    end
    check_eq("t5_mem_bad", nbad, 0);
    check_eq("t5_wr_q_empty", wr_q.size(), 0);

    // 6: reset mid-read, then a re-issued request
    C0_AD = 16'hF000; C0_REQ = 1'b1;
    step();
    RESET = 1'b1;
    #1;
    check_all_zero("t6_async");
    C0_REQ = 1'b0;
    base = ack_cnt0;
    step();
    step();
    check_eq("t6_no_ack", ack_cnt0 - base, 0);
    RESET = 1'b0;
    C0_REQ = 1'b1;
    step();
    check_eq("t6_ack_e1", C0_ACK, 1'b0);
    step();
    check_eq("t6_ack_e2", C0_ACK, 1'b0);
    step();
    check_eq("t6_ack_e3", C0_ACK, 1'b1);
    C0_REQ = 1'b0;
    repeat (3) step();

    // Randomized traffic: reads in the upper half, writes in the lower half
    do_reset();
    wait0 = 0; wait1 = 0; since_wr = 10;
    for (int n = 0; n < 1500; n++) begin
      if (C0_REQ) begin
        if (C0_ACK) begin
          check_eq("r_c0_latency", wait0 <= 16, 1'b1);
          C0_REQ = 1'b0;
        end else begin
          wait0++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        C0_AD = 16'h8000 | 16'($urandom_range(0, 32767));
        C0_REQ = 1'b1;
        wait0 = 0;
      end
      if (C1_REQ) begin
        if (C1_ACK) begin
          check_eq("r_c1_latency", wait1 <= 16, 1'b1);
          C1_REQ = 1'b0;
        end else begin
          wait1++;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        C1_AD = 16'h8000 | 16'($urandom_range(0, 32767));
        C1_REQ = 1'b1;
        wait1 = 0;
      end
      since_wr++;
      if (since_wr >= 6 && $urandom_range(0, 2) == 0) begin
        dl_write(16'($urandom_range(0, 32767)), 8'($urandom));
        since_wr = 0;
      end else begin
        DL_WR = 1'b0;
      end
      step();
    end
    if (C0_REQ) check_eq("r_c0_pending", wait0 <= 16, 1'b1);
    if (C1_REQ) check_eq("r_c1_pending", wait1 <= 16, 1'b1);
    DL_WR = 1'b0; C0_REQ = 1'b0; C1_REQ = 1'b0;
    repeat (10) step();
    check_eq("r_writes_drained", wr_q.size(), 0);
    check_eq("r_ovf", DL_OVF, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
